sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's fixed 128-bit FIFO.
- Adds:
  - configurable width and depth;
  - programmable almost-full/almost-empty thresholds;
  - occupancy count;
  - sticky overflow/underflow error flags;
  - an explicit read-valid strobe.
- Sits between producer and consumer agents/DUT logic on the same clock domain.
- Standard (registered-read) mode by default; first-word-fall-through when the optional feature is compiled in.

---
 rtl/sync_fifo_param.sv | 156 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and an explicit read-valid strobe.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through. o_rddata shows the
//                              head entry whenever the FIFO is non-empty, and
//                              o_rdvalid = !o_empty.
//                 undefined -> registered read with one cycle of latency
//                              (the default).
//
// Ports:
//   clk          clock; all logic is on the rising edge
//   rst          synchronous reset, active-high; takes priority over all inputs
//   i_wren       write request
//   i_wrdata     write data, captured when a write is accepted
//   i_rden       read (pop) request
//   i_clr_err    clears o_overflow and o_underflow
//   o_rddata     read data
//   o_rdvalid    o_rddata holds a newly popped word (standard mode),
//                or the head entry is valid (FWFT mode)
//   o_full       count == DEPTH
//   o_empty      count == 0
//   o_alm_full   count >= AF_THRESH
//   o_alm_empty  count <= AE_THRESH
//   o_count      current occupancy
//   o_overflow   sticky: a write was attempted while full and was not accepted
//   o_underflow  sticky: a read was attempted while empty
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Configuration is checked at elaboration time. A bad configuration stops the build.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $fatal(1, "sync_fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, alm_full_q, alm_empty_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             rd_acc, wr_acc;

    // A read is accepted only when the FIFO holds data. When the FIFO is full,
    // a write is still accepted if a read frees a slot in the same cycle.
    always_comb begin
        rd_acc   = i_rden & ~empty_q;
        wr_acc   = i_wren & (~full_q | rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        // Setting an error flag wins over clearing it in the same cycle.
        ovf_d    = (i_wren & ~wr_acc) | (ovf_q & ~i_clr_err);
        udf_d    = (i_rden & empty_q) | (udf_q & ~i_clr_err);
    end

    // Status flags are registered from the next-state count, so they change
    // on the same edge as o_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            alm_full_q  <= (count_d >= CNT_W'(AF_THRESH));
            alm_empty_q <= (count_d <= CNT_W'(AE_THRESH));
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // The storage array is not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= i_wrdata;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head entry is presented combinationally. Output zero while the FIFO is empty.
    always_comb begin
        o_rddata  = empty_q ? '0 : mem[rd_ptr_q];
        o_rdvalid = ~empty_q;
    end
`else
    logic [DATA_W-1:0] rddata_q;
    logic              rdvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rdvalid_q <= rd_acc;
            if (rd_acc) begin
                rddata_q <= mem[rd_ptr_q];
            end
        end
    end

    always_comb begin
        o_rddata  = rddata_q;
        o_rdvalid = rdvalid_q;
    end
`endif

    always_comb begin
        o_full      = full_q;
        o_empty     = empty_q;
        o_alm_full  = alm_full_q;
        o_alm_empty = alm_empty_q;
        o_count     = count_q;
        o_overflow  = ovf_q;
        o_underflow = udf_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wren = 1'b0;
    logic [DATA_W-1:0] wrdata = '0;
    logic              rden = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] rddata;
    logic              rdvalid, full, empty, alm_full, alm_empty, ovf, udf;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int failures = 0;

    // Expected read data, in order. The stimulus pushes it and the monitor pops it.
    logic [DATA_W-1:0] exp_q[$];

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(14),
        .AE_THRESH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wren     (wren),
        .i_wrdata   (wrdata),
        .i_rden     (rden),
        .i_clr_err  (clr_err),
        .o_rddata   (rddata),
        .o_rdvalid  (rdvalid),
        .o_full     (full),
        .o_empty    (empty),
        .o_alm_full (alm_full),
        .o_alm_empty(alm_empty),
        .o_count    (count),
        .o_overflow (ovf),
        .o_underflow(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus. Return 1 ns after the edge, with inputs idle.
    task automatic cyc(input logic wr, input logic [DATA_W-1:0] d, input logic rd,
                       input logic clr);
        wren = wr;
        wrdata = d;
        rden = rd;
        clr_err = clr;
        @(posedge clk);
        #1;
        wren = 1'b0;
        rden = 1'b0;
        clr_err = 1'b0;
    endtask

    // Monitor. Sample on the falling edge. In standard mode it consumes one
    // expected word per o_rdvalid cycle. In FWFT mode it consumes the head
    // word when it is being popped.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
`ifdef FIFO_FWFT_EN
        if (!rst && rdvalid && rden) begin
`else
        if (!rst && rdvalid) begin
`endif
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read word", rddata);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", rddata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle.
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("rst_empty", empty, 1);
        chk("rst_alm_empty", alm_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alm_full", alm_full, 0);
        chk("rst_count", count, 0);
        chk("rst_rddata", rddata, 0);
        chk("rst_rdvalid", rdvalid, 0);
        chk("rst_flags", {ovf, udf}, 0);

        // Fill with 0x1..0x10.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
            chk("fill_count", count, i);
            chk("fill_alm_empty", alm_empty, (i <= 2) ? 1 : 0);
            chk("fill_alm_full", alm_full, (i >= 14) ? 1 : 0);
            chk("fill_full", full, (i == 16) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end

        // A write while full sets overflow. A clear in the same cycle as a new overflow loses.
        cyc(1'b1, 128'h99, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 16);
        cyc(1'b1, 128'h98, 1'b0, 1'b1);
        chk("ovf_set_wins", ovf, 1);
        chk("ovf_no_udf", udf, 0);

        // Drain. The data must be 0x1..0x10 in order, with the rejected words absent.
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(DATA_W'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_count", count, 16 - i);
`ifndef FIFO_FWFT_EN
            chk("drain_rdvalid", rdvalid, 1);
`endif
        end
        chk("drain_empty", empty, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("drain_rdvalid_off", rdvalid, 0);
        chk("drain_scoreboard", exp_q.size(), 0);

        // Read and write at the same time while full. Count stays at 16.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, DATA_W'(32'h21 + i), 1'b0, 1'b0);
        exp_q.push_back(128'h21);
        cyc(1'b1, 128'hAA, 1'b1, 1'b0);
        chk("rw_full_count", count, 16);
        chk("rw_full_full", full, 1);
        chk("rw_full_no_ovf", ovf, 0);
        for (int i = 1; i < 16; i++) begin
            exp_q.push_back(DATA_W'(32'h21 + i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        exp_q.push_back(128'hAA);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("rw_full_drained", count, 0);

        // Empty FIFO: a read alone is an underflow. A read with a write accepts only the write.
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("udf_set", udf, 1);
        chk("udf_rdvalid", rdvalid, 0);
        cyc(1'b1, 128'h77, 1'b1, 1'b0);
        chk("rw_empty_count", count, 1);
        chk("rw_empty_udf", udf, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("clr_flags", {ovf, udf}, 0);
        exp_q.push_back(128'h77);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pop77_count", count, 0);

        // Reset during operation.
        for (int i = 0; i < 9; i++) cyc(1'b1, DATA_W'(32'h40 + i), 1'b0, 1'b0);
        chk("pre_rst_count", count, 9);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_rddata", rddata, 0);
        cyc(1'b1, 128'h5A5A, 1'b0, 1'b0);
        exp_q.push_back(128'h5A5A);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_count", count, 0);

`ifdef FIFO_FWFT_EN
        // The head word appears without any read request.
        cyc(1'b1, 128'h55, 1'b0, 1'b0);
        chk("fwft_rddata", rddata, 128'h55);
        chk("fwft_rdvalid", rdvalid, 1);
        exp_q.push_back(128'h55);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_rdvalid_off", rdvalid, 0);
`endif

        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("final_scoreboard", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
